// File: rtl/d_stream_tx.sv
// rtl/d_stream_tx.sv - buffer-driven stream transmitter with loop and abort
// A small word buffer is loaded while idle and replayed on a valid/ready stream.
module d_stream_tx #(
    parameter int dataWidth = 32,
    parameter int bufDepth  = 16,
    parameter int addrWidth = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cfgWe,
    input  logic [addrWidth-1:0] cfgAddr,
    input  logic [dataWidth-1:0] cfgData,
    input  logic [addrWidth:0]   len,
    input  logic                 loop,
    input  logic                 start,
    input  logic                 stop,
    output logic [dataWidth-1:0] dout,
    output logic                 doutValid,
    input  logic                 doutReady,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [addrWidth:0] ONE = {{addrWidth{1'b0}}, 1'b1};

    state_t               state;
    logic [dataWidth-1:0] mem [bufDepth];
    logic [addrWidth:0]   idx;
    logic [addrWidth:0]   len_q;
    logic                 loop_q;
    logic [addrWidth:0]   idx_next;
    logic                 xfer;
    logic                 last;

    assign xfer     = doutValid & doutReady;
    assign last     = (idx == (len_q - ONE));
    assign idx_next = idx + ONE;
    assign busy     = (state != IDLE);

    // Buffer is intentionally left out of reset so contents survive an abort.
    always_ff @(posedge clock) begin
        if (cfgWe && state == IDLE) begin
            mem[cfgAddr] <= cfgData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dout      <= '0;
            doutValid <= 1'b0;
            done      <= 1'b0;
            idx       <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q  <= len;
                        loop_q <= loop;
                        idx    <= '0;
                        if (len != '0) begin
                            dout      <= mem[0];
                            doutValid <= 1'b1;
                            state     <= SEND;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                SEND: begin
                    // An offered word is never withdrawn: stop only acts on acceptance.
                    if (xfer) begin
                        if (stop || (last && !loop_q)) begin
                            doutValid <= 1'b0;
                            done      <= 1'b1;
                            state     <= FINISH;
                        end else if (last) begin
                            idx  <= '0;
                            dout <= mem[0];
                        end else begin
                            idx  <= idx_next;
                            dout <= mem[idx_next[addrWidth-1:0]];
                        end
                    end else if (!doutValid && stop) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    doutValid <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
